// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared encodings, FSM states and the captured-request record for dmem_arbiter.
package dmem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        port;
    } owner_t;

    // Reserved size counts as an error alongside misaligned half/word accesses.
    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] a);
        return size == SZ_HALF ? a[0] : size == SZ_WORD ? a != 2'b00 : size != SZ_BYTE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: both requester ports plus the memory word port of dmem_arbiter.
interface dmem_arbiter_if;
    logic        p0_req, p0_we, p0_unsigned, p0_gnt, p0_rvalid, p0_err;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_unsigned, p1_gnt, p1_rvalid, p1_err;
    logic [1:0]  p1_size;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    modport master (
        output p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_lane_merge.sv
// dmem_lane_merge: little-endian lane extract/extend for loads and lane replace for sub-word stores.
module dmem_lane_merge
    import dmem_arb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] sdata
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        ldata = size == SZ_BYTE ? {{24{b[7] & ~uns}}, b} :
                size == SZ_HALF ? {{16{h[15] & ~uns}}, h} : word;
        sdata = word;
        if (size == SZ_BYTE)
            sdata[8*off +: 8] = wdata[7:0];
        else if (size == SZ_HALF)
            sdata[16*off[1] +: 16] = wdata[15:0];
        else
            sdata = wdata;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for a single-cycle word memory (RMW for sub-word stores).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    state_t      state, nxt;
    owner_t      own, req_cap;
    logic [31:0] merge_q, result_q, ldata, sdata;
    logic        err_q, win, any_req, grant, cap_err, resp, sub_store;

    assign any_req = bus.p0_req | bus.p1_req;

`ifdef DMEM_ARB_RR_EN
    logic prio;
    always_ff @(posedge clk)
        if (rst) prio <= 1'b0;
        else if (grant) prio <= ~win;
    assign win = (bus.p0_req & bus.p1_req) ? prio : bus.p1_req;
`else
    assign win = ~bus.p0_req;
`endif

    assign req_cap = win ? {bus.p1_we, bus.p1_size, bus.p1_unsigned, bus.p1_addr, bus.p1_wdata, 1'b1}
                         : {bus.p0_we, bus.p0_size, bus.p0_unsigned, bus.p0_addr, bus.p0_wdata, 1'b0};
    assign cap_err   = bad_access(req_cap.size, req_cap.addr[1:0]);
    assign sub_store = own.we & (own.size != SZ_WORD);
    assign grant     = (state == IDLE) & any_req & ~rst;
    assign resp      = (state == RESP) & ~rst;

    // One lane unit serves both phases: live memory word on loads, merge register on the write.
    dmem_lane_merge u_lane (
        .word  (state == WRITE ? merge_q : bus.mem_rdata),
        .off   (own.addr[1:0]),
        .size  (own.size),
        .uns   (own.uns),
        .wdata (own.wdata),
        .ldata (ldata),
        .sdata (sdata)
    );

    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = any_req ? (cap_err ? RESP : ACCESS) : IDLE;
            ACCESS:  nxt = sub_store ? WRITE : RESP;
            WRITE:   nxt = RESP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) begin
            own      <= '0;
            merge_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (grant) begin
            own      <= req_cap;
            result_q <= '0;
            err_q    <= cap_err;
        end else if (state == ACCESS) begin
            result_q <= own.we ? result_q : ldata;
            merge_q  <= own.we ? bus.mem_rdata : merge_q;
        end

    assign bus.mem_we    = ~rst & ((state == ACCESS & own.we & ~sub_store) | state == WRITE);
    assign bus.mem_addr  = {own.addr[31:2], 2'b00};
    assign bus.mem_wdata = state == WRITE ? sdata : own.wdata;

    assign bus.p0_gnt    = grant & ~win;
    assign bus.p1_gnt    = grant & win;
    assign bus.p0_rvalid = resp & ~own.port;
    assign bus.p1_rvalid = resp & own.port;
    assign bus.p0_rdata  = bus.p0_rvalid ? result_q : '0;
    assign bus.p1_rdata  = bus.p1_rvalid ? result_q : '0;
    assign bus.p0_err    = bus.p0_rvalid & err_q;
    assign bus.p1_err    = bus.p1_rvalid & err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: transaction-level reference model checked against dmem_arbiter every cycle.
module tb_dmem_arbiter;
    typedef struct { bit we; bit [1:0] size; bit uns; bit [31:0] addr; bit [31:0] wdata; } rq_t;
    typedef struct { rq_t r; bit port; bit err; } tx_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [16];
    bit   [31:0] ref_mem [16];
    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    int n_cmp, n_fail, rst_cycles, cyc;
    rq_t q0[$], q1[$], cur0, cur1;
    bit have0, have1, gaps, abort_arm;
    bit pend_we;
    bit [3:0] pend_a;
    bit [31:0] pend_d;
    bit m_active;
    bit m_last = 1;
    int m_t;
    tx_t m_tx;
    bit [32:0] resp0[$], resp1[$];
    bit glog[$];
    bit [63:0] wlog[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit is_err(rq_t r);
        return r.size == 3 || (r.size == 1 && r.addr % 2 != 0) || (r.size == 2 && r.addr % 4 != 0);
    endfunction

    function automatic int wr_cycle(tx_t t);
        return (t.err || !t.r.we) ? 0 : (t.r.size == 2 ? 1 : 2);
    endfunction

    function automatic int tx_len(tx_t t);
        return t.err ? 1 : (t.r.we && t.r.size != 2) ? 3 : 2;
    endfunction

    function automatic bit [31:0] load_val(rq_t r);
        bit [31:0] w = ref_mem[r.addr[5:2]] >> (8 * r.addr[1:0]);
        if (r.size == 2) return w;
        if (r.size == 0) begin
            w = w % 256;
            if (!r.uns && w >= 128) w = w - 256;
        end else begin
            w = w % 65536;
            if (!r.uns && w >= 32768) w = w - 65536;
        end
        return w;
    endfunction

    function automatic bit [31:0] store_val(rq_t r);
        bit [31:0] m = (r.size == 0 ? 32'hFF : 32'hFFFF) << (8 * r.addr[1:0]);
        if (r.size == 2) return r.wdata;
        return (ref_mem[r.addr[5:2]] & ~m) | ((r.wdata << (8 * r.addr[1:0])) & m);
    endfunction

    function automatic rq_t mk(bit we, bit [1:0] size, bit uns, bit [31:0] addr, bit [31:0] wdata);
        rq_t r;
        r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic rq_t rand_rq();
        rq_t r;
        r.we    = 1'($urandom_range(1));
        r.size  = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
        r.uns   = 1'($urandom_range(1));
        r.addr  = $urandom_range(63);
        r.wdata = $urandom;
        if ($urandom_range(3) != 0) begin
            if (r.size == 1) r.addr[0] = 1'b0;
            if (r.size == 2) r.addr[1:0] = 2'b00;
        end
        return r;
    endfunction

    task automatic step();
        bit e_g0, e_g1, e_we, e_rv0, e_rv1, e_err, win;
        bit [31:0] e_rd, e_addr, e_wd;
        @(negedge clk);
        if (pend_we) mem[pend_a] = pend_d;
        rst = rst_cycles > 0;
        if (rst_cycles > 0) rst_cycles--;
        if (!have0 && q0.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin cur0 = q0.pop_front(); have0 = 1; end
        if (!have1 && q1.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin cur1 = q1.pop_front(); have1 = 1; end
        bus.p0_req = have0; bus.p0_we = cur0.we; bus.p0_size = cur0.size;
        bus.p0_unsigned = cur0.uns; bus.p0_addr = cur0.addr; bus.p0_wdata = cur0.wdata;
        bus.p1_req = have1; bus.p1_we = cur1.we; bus.p1_size = cur1.size;
        bus.p1_unsigned = cur1.uns; bus.p1_addr = cur1.addr; bus.p1_wdata = cur1.wdata;
        if (abort_arm && m_active && m_t == 2 && wr_cycle(m_tx) == 2) begin rst = 1; abort_arm = 0; end
        #1;
        {e_g0, e_g1, e_we, e_rv0, e_rv1, e_err} = '0;
        e_rd = 0; e_addr = 0; e_wd = 0;
`ifdef DMEM_ARB_RR_EN
        win = (have0 && have1) ? !m_last : have1;
`else
        win = !have0;
`endif
        if (!rst && !m_active && (have0 || have1)) begin e_g0 = !win; e_g1 = win; end
        if (!rst && m_active) begin
            if (m_t == wr_cycle(m_tx)) begin
                e_we = 1; e_addr = m_tx.r.addr & ~32'h3; e_wd = store_val(m_tx.r);
            end
            if (m_t == tx_len(m_tx)) begin
                e_rv0 = !m_tx.port; e_rv1 = m_tx.port; e_err = m_tx.err;
                e_rd = (m_tx.err || m_tx.r.we) ? 0 : load_val(m_tx.r);
            end
        end
        chk("p0_gnt", bus.p0_gnt, e_g0);
        chk("p1_gnt", bus.p1_gnt, e_g1);
        chk("mem_we", bus.mem_we, e_we);
        chk("p0_rvalid", bus.p0_rvalid, e_rv0);
        chk("p1_rvalid", bus.p1_rvalid, e_rv1);
        chk("p0_rdata", bus.p0_rdata, e_rv0 ? e_rd : 0);
        chk("p1_rdata", bus.p1_rdata, e_rv1 ? e_rd : 0);
        chk("p0_err", bus.p0_err, e_rv0 & e_err);
        chk("p1_err", bus.p1_err, e_rv1 & e_err);
        if (e_we) begin
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wd);
        end
        if (bus.p0_rvalid) resp0.push_back({bus.p0_err, bus.p0_rdata});
        if (bus.p1_rvalid) resp1.push_back({bus.p1_err, bus.p1_rdata});
        if (bus.p0_gnt) glog.push_back(0);
        if (bus.p1_gnt) glog.push_back(1);
        if (bus.mem_we) wlog.push_back({bus.mem_addr, bus.mem_wdata});
        pend_we = bus.mem_we; pend_a = bus.mem_addr[5:2]; pend_d = bus.mem_wdata;
        if (rst) begin
            m_active = 0; m_last = 1;
        end else if (m_active) begin
            if (e_we) ref_mem[m_tx.r.addr[5:2]] = e_wd;
            if (m_t == tx_len(m_tx)) m_active = 0;
            else m_t++;
        end else if (have0 || have1) begin
            m_tx.r = win ? cur1 : cur0; m_tx.port = win; m_tx.err = is_err(m_tx.r);
            m_active = 1; m_t = 1; m_last = win;
        end
        if (bus.p0_gnt) have0 = 0;
        if (bus.p1_gnt) have1 = 0;
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || have0 || have1 || m_active) && n < 20000) begin
            step();
            n++;
        end
        chk("drain_within_budget", n < 20000, 1);
        step();
    endtask

    initial begin
        int n_resp0;
        for (int i = 0; i < 16; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        mem[3] = 32'h8899AABB; ref_mem[3] = 32'h8899AABB;
        mem[4] = 32'hCAFEF00D; ref_mem[4] = 32'hCAFEF00D;
        cur0 = mk(0, 0, 0, 0, 0); cur1 = cur0;
        bus.p0_req = 0; bus.p1_req = 0;
        rst_cycles = 3;
        repeat (4) step();
        chk("reset_mem_addr", bus.mem_addr, 0);
        chk("reset_mem_wdata", bus.mem_wdata, 0);

        // Lane extraction/extension and a byte read-modify-write on word 0x0C.
        q0.push_back(mk(0, 0, 0, 32'h0D, 0));
        q0.push_back(mk(0, 1, 1, 32'h0E, 0));
        q0.push_back(mk(1, 0, 0, 32'h0D, 32'hFFFFFF5A));
        q0.push_back(mk(0, 2, 0, 32'h0C, 0));
        wlog.delete();
        drain();
        chk("lit_lb_signed", resp0[0], {1'b0, 32'hFFFFFFAA});
        chk("lit_lhu", resp0[1], {1'b0, 32'h00008899});
        chk("lit_sb_resp", resp0[2], 33'h0);
        chk("lit_lw_after_sb", resp0[3], {1'b0, 32'h88995ABB});
        chk("lit_sb_write_count", wlog.size(), 1);
        chk("lit_sb_write", wlog[0], {32'h0C, 32'h88995ABB});

        q1.push_back(mk(0, 2, 0, 32'h06, 0));
        drain();
        chk("lit_misaligned_resp", resp1[0], {1'b1, 32'h0});
        chk("lit_misaligned_no_write", wlog.size(), 1);

        glog.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 2, 0, 32'($urandom_range(15) * 4), 0));
            q1.push_back(mk(0, 2, 0, 32'($urandom_range(15) * 4), 0));
        end
        drain();
`ifdef DMEM_ARB_RR_EN
        chk("lit_grant_order", {glog[0], glog[1], glog[2], glog[3]}, 4'b0101);
`else
        chk("lit_grant_order", {glog[0], glog[1], glog[2], glog[3]}, 4'b0000);
`endif

        // Reset lands in the write cycle of a half store: nothing written, no response.
        n_resp0 = resp0.size();
        wlog.delete();
        abort_arm = 1;
        q0.push_back(mk(1, 1, 0, 32'h10, 32'h1234));
        drain();
        chk("lit_abort_mem_addr", bus.mem_addr, 0);
        chk("lit_abort_mem_wdata", bus.mem_wdata, 0);
        chk("lit_abort_no_rvalid", resp0.size(), n_resp0);
        q0.push_back(mk(0, 2, 0, 32'h10, 0));
        drain();
        chk("lit_abort_mem_unchanged", resp0[n_resp0], {1'b0, 32'hCAFEF00D});
        chk("lit_abort_no_write", wlog.size(), 0);

        gaps = 1;
        for (int i = 0; i < 250; i++) begin
            q0.push_back(rand_rq());
            q1.push_back(rand_rq());
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-cycle data memory. Shares the memory's single word port between the core load/store unit (port 0) and a loader/debug master (port 1). Converts byte/halfword/word requests into the memory's full-word, little-endian, combinational-read / clocked-write protocol. Sub-word stores run as read-modify-write; loads are sign- or zero-extended.

## Interface
- No parameters. Widths are fixed at 32-bit address and data.
- `clk` in 1: single clock; memory writes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pN_req` in 1 (N=0,1): request valid; held until `pN_gnt`.
- `pN_we` in 1: 1 = store, 0 = load.
- `pN_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `pN_unsigned` in 1: zero-extend loads when 1, sign-extend when 0.
- `pN_addr` in 32: byte address.
- `pN_wdata` in 32: store data, right-aligned.
- `pN_gnt` out 1: request accepted this cycle (combinational, IDLE only).
- `pN_rvalid` out 1: one-cycle completion pulse.
- `pN_rdata` out 32: extended load data, valid with `pN_rvalid`; 0 for stores.
- `pN_err` out 1: misaligned or reserved size, valid with `pN_rvalid`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word-aligned address (`addr & ~3`).
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: memory read word, combinational from `mem_addr` while `mem_we`=0.

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE: arbitrate among asserted `pN_req`, assert the winner's `gnt`, and capture its request into an owner register. Go to ACCESS, or to RESP with error.
- Errors: half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11. The request goes directly to RESP with `err`=1 and `rdata`=0. No memory write is performed.
- ACCESS:
  - `mem_addr` driven, `mem_we`=0.
  - Load: extract the lane at `addr[1:0]`, extend it, latch the result, go to RESP.
  - Word store: `mem_we`=1 with `mem_wdata`=`wdata`, then go to RESP.
  - Byte/half store: latch `mem_rdata` into the merge register, then go to WRITE.
- WRITE: `mem_we`=1. `mem_wdata` = merge register with the addressed byte or half replaced by `wdata[7:0]` or `wdata[15:0]`. Then go to RESP.
- RESP: pulse the owner's `rvalid` with `rdata`/`err`, then go to IDLE. The non-owner's outputs stay 0.
- Byte lanes are little-endian: lane k = `mem_rdata[8k+7:8k]`. Half at offset 2 = `[31:16]`.

## Timing
- Cycle 0 = IDLE cycle in which `gnt` is high.
- Load: `rvalid` in cycle 2.
- Word store: `mem_we` in cycle 1, `rvalid` in cycle 2.
- Sub-word store: `mem_we` in cycle 2, `rvalid` in cycle 3.
- Error: `rvalid`+`err` in cycle 1.
- Next grant is possible in the cycle after RESP. Peak rate is one access per 3 cycles (4 for sub-word stores).
- Requests arriving outside IDLE wait; `gnt` is never asserted outside IDLE.
- Simultaneous requests in IDLE resolve per Configuration; the loser keeps `req` high and is granted in the next IDLE.
- Reset values: all outputs 0, state IDLE, owner/merge/result registers 0, round-robin pointer favouring port 0.
- `rst` in any cycle: next state IDLE. With `rst` high, `mem_we` is forced 0 combinationally, so an in-flight write in that cycle is dropped. No `rvalid` is issued for the aborted request.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration. A 1-bit last-grant pointer gives priority to the port not granted last; it updates only on grant.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 (core) always wins. No pointer register exists.

## Structure
- Package `dmem_arb_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - state enum;
  - owner register typedef (we, size, unsigned, addr, wdata, port id).
- Sub-module `dmem_lane_merge`, combinational:
  - load lane extract plus sign/zero extension;
  - store lane merge, given word, offset, size and wdata.

## Test plan
- Memory word 0x0C holds 0x8899AABB. Port 0 loads byte at 0x0D, signed → `rdata`=0xFFFFFFAA, `rvalid` in cycle 2. Unsigned half at 0x0E → 0x00008899.
- Port 0 stores byte 0x5A at 0x0D → `mem_we` only in cycle 2 with `mem_addr`=0x0C, `mem_wdata`=0x88995ABB. A subsequent word load returns 0x88995ABB.
- Both ports request in IDLE repeatedly:
  - RR_EN: grants alternate 0,1,0,1.
  - Without RR_EN: port 0 is always granted while its `req` stays high.
- Port 1 word load at 0x06 → `rvalid`+`err` in cycle 1, `rdata`=0, `mem_we` never asserted.
- `rst` asserted in the WRITE cycle of a half store to 0x10 → `mem_we`=0 that cycle, memory unchanged, no `rvalid`, next cycle IDLE with all outputs 0.
